// File: rtl/game_setup_gen.sv
// Runtime game configuration: level decode, board geometry/timer, LFSR mine placement and bitmap query.
// Optional MINE_SCAN_FALLBACK_EN adds a linear-scan fallback after 1023 consecutive rejects.
module game_setup_gen #(
   parameter int          MAX_DIM      = 16,
   parameter int          FIELD_SIZE   = 64,
   parameter int          X_CENTER     = 512,
   parameter int          Y_CENTER     = 384,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          CUSTOM_TIMER = 60,
   localparam int         IDX_W        = $clog2(MAX_DIM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       level,
   input  logic [4:0]       custom_dim,
   input  logic [7:0]       custom_mines,
   output logic             busy,
   output logic             done,
   output logic             cfg_valid,
   output logic [4:0]       dim,
   output logic [7:0]       mine_num,
   output logic [7:0]       timer_sec,
   output logic [10:0]      board_size,
   output logic [10:0]      board_xpos,
   output logic [10:0]      board_ypos,
   output logic             mine_we,
   output logic [IDX_W-1:0] mine_row,
   output logic [IDX_W-1:0] mine_col,
   input  logic [IDX_W-1:0] q_row,
   input  logic [IDX_W-1:0] q_col,
   output logic             q_mine
);

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_PLACE, S_DONE} state_t;

   localparam logic [4:0]  MAX_DIM5 = 5'(MAX_DIM);
   localparam logic [10:0] XC       = 11'(X_CENTER);
   localparam logic [10:0] YC       = 11'(Y_CENTER);

   state_t state, state_nxt;

   logic [15:0]                       lfsr, lfsr_nxt;
   logic [MAX_DIM-1:0][MAX_DIM-1:0]   bitmap;
   logic [7:0]                        cnt;

   // level decode and clamping, consumed in LATCH
   logic [4:0]  raw_dim, n_dim;
   logic [7:0]  raw_mines, n_mines, n_timer;
   logic [9:0]  n_sq, mine_cap;
   logic [10:0] n_size, n_half, n_xpos, n_ypos;

   always_comb begin
      raw_dim   = custom_dim;
      raw_mines = custom_mines;
      n_timer   = 8'(CUSTOM_TIMER);
      case (level)
         2'd0:    begin raw_dim = 5'd8;  raw_mines = 8'd19; n_timer = 8'd45; end
         2'd1:    begin raw_dim = 5'd10; raw_mines = 8'd30; n_timer = 8'd50; end
         2'd2:    begin raw_dim = 5'd15; raw_mines = 8'd40; n_timer = 8'd70; end
         default: ;
      endcase

      n_dim = raw_dim;
      if (raw_dim < 5'd4)
         n_dim = 5'd4;
      else if (raw_dim > MAX_DIM5)
         n_dim = MAX_DIM5;

      // cap keeps at least one free cell so placement always terminates
      n_sq     = 10'(n_dim) * 10'(n_dim);
      mine_cap = n_sq - 10'd1;
      n_mines  = raw_mines;
      if (raw_mines == 8'd0)
         n_mines = 8'd1;
      else if (10'(raw_mines) > mine_cap)
         n_mines = mine_cap[7:0];

      n_size = 11'(FIELD_SIZE) * 11'(n_dim);
      n_half = {1'b0, n_size[10:1]};
      n_xpos = (n_half > XC) ? 11'd0 : XC - n_half;
      n_ypos = (n_half > YC) ? 11'd0 : YC - n_half;
   end

   assign lfsr_nxt = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};

   // candidate cell selection
   logic [IDX_W-1:0] cand_row, cand_col;
   logic             in_range, accept, last;

`ifdef MINE_SCAN_FALLBACK_EN
   logic [9:0]         rej_cnt;
   logic [2*IDX_W-1:0] scan_ptr;
   logic               scan_mode;

   assign scan_mode = (rej_cnt == 10'h3FF);

   always_comb begin
      cand_row = lfsr[2*IDX_W-1:IDX_W];
      cand_col = lfsr[IDX_W-1:0];
      if (scan_mode) begin
         cand_row = scan_ptr[2*IDX_W-1:IDX_W];
         cand_col = scan_ptr[IDX_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rej_cnt  <= '0;
         scan_ptr <= '0;
      end else if (state == S_LATCH || accept) begin
         rej_cnt  <= '0;
         scan_ptr <= '0;
      end else if (state == S_PLACE) begin
         if (scan_mode)
            scan_ptr <= scan_ptr + 1'b1;
         else
            rej_cnt <= rej_cnt + 10'd1;
      end
   end
`else
   always_comb begin
      cand_row = lfsr[2*IDX_W-1:IDX_W];
      cand_col = lfsr[IDX_W-1:0];
   end
`endif

   assign in_range = (dim > 5'(cand_row)) && (dim > 5'(cand_col));
   assign accept   = (state == S_PLACE) && in_range && !bitmap[cand_row][cand_col];
   assign last     = accept && (cnt + 8'd1 == mine_num);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_PLACE;
         S_PLACE: if (last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_LATCH) || (state == S_PLACE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr       <= LFSR_SEED;
         bitmap     <= '0;
         cnt        <= '0;
         cfg_valid  <= 1'b0;
         dim        <= '0;
         mine_num   <= '0;
         timer_sec  <= '0;
         board_size <= '0;
         board_xpos <= '0;
         board_ypos <= '0;
         mine_we    <= 1'b0;
         mine_row   <= '0;
         mine_col   <= '0;
      end else begin
         lfsr    <= lfsr_nxt;
         mine_we <= accept;
         if (accept) begin
            mine_row                   <= cand_row;
            mine_col                   <= cand_col;
            bitmap[cand_row][cand_col] <= 1'b1;
            cnt                        <= cnt + 8'd1;
         end
         if (last)
            cfg_valid <= 1'b1;
         if (state == S_IDLE && start)
            cfg_valid <= 1'b0;
         if (state == S_LATCH) begin
            dim        <= n_dim;
            mine_num   <= n_mines;
            timer_sec  <= n_timer;
            board_size <= n_size;
            board_xpos <= n_xpos;
            board_ypos <= n_ypos;
            bitmap     <= '0;
            cnt        <= '0;
         end
      end
   end

   assign q_mine = (dim > 5'(q_row)) && (dim > 5'(q_col)) && bitmap[q_row][q_col];

endmodule

// File: tb/tb_game_setup_gen.sv
// Directed bench for game_setup_gen: presets, custom clamping, start handling, async reset, dense fill.
module tb_game_setup_gen;

   localparam int BUDGET = 60000;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [1:0] level;
   logic [4:0] custom_dim;
   logic [7:0] custom_mines;
   logic       busy, done, cfg_valid, mine_we, q_mine;
   logic [4:0] dim;
   logic [7:0] mine_num, timer_sec;
   logic [10:0] board_size, board_xpos, board_ypos;
   logic [3:0] mine_row, mine_col, q_row, q_col;

   int n_cmp = 0;
   int n_err = 0;

   game_setup_gen dut (
      .clk(clk), .rst(rst), .start(start), .level(level),
      .custom_dim(custom_dim), .custom_mines(custom_mines),
      .busy(busy), .done(done), .cfg_valid(cfg_valid), .dim(dim),
      .mine_num(mine_num), .timer_sec(timer_sec), .board_size(board_size),
      .board_xpos(board_xpos), .board_ypos(board_ypos), .mine_we(mine_we),
      .mine_row(mine_row), .mine_col(mine_col), .q_row(q_row), .q_col(q_col),
      .q_mine(q_mine)
   );

   always #5 clk = ~clk;

   // strobe monitor: records placements of the current generation
   logic [15:0][15:0] tb_map;
   int we_cnt, dup_cnt, oor_cnt, done_cnt;
   logic busy_q = 1'b0;

   initial begin
      tb_map = '0; we_cnt = 0; dup_cnt = 0; oor_cnt = 0; done_cnt = 0;
   end

   always @(negedge clk) begin
      if (busy && !busy_q) begin
         tb_map = '0; we_cnt = 0; dup_cnt = 0; oor_cnt = 0;
      end
      if (mine_we) begin
         if (tb_map[mine_row][mine_col]) dup_cnt++;
         tb_map[mine_row][mine_col] = 1'b1;
         we_cnt++;
         if (5'(mine_row) >= dim || 5'(mine_col) >= dim) oor_cnt++;
      end
      if (done) done_cnt++;
      busy_q = busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_lt(input string tag, input int obs, input int lim);
      n_cmp++;
      assert (obs < lim) else begin
         n_err++;
         $error("FAIL %s: got %0d expected below %0d", tag, obs, lim);
      end
   endtask

   // walks the whole 16x16 query space; cells outside d must read 0
   task automatic scan_map(input int d, output int pop, output int mis);
      pop = 0; mis = 0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            q_row = 4'(r); q_col = 4'(c);
            #1;
            if (q_mine === 1'b1) pop++;
            if (q_mine !== ((r < d && c < d) ? tb_map[r][c] : 1'b0)) mis++;
         end
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < BUDGET) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk({tag, "_done_seen"}, done, 1);
      chk({tag, "_we_with_done"}, mine_we, 1);
      chk({tag, "_valid_at_done"}, cfg_valid, 1);
      chk({tag, "_busy_at_done"}, busy, 0);
   endtask

   task automatic gen(input string tag, input logic [1:0] lv, input logic [4:0] cd,
                      input logic [7:0] cm, output int cyc);
      level = lv; custom_dim = cd; custom_mines = cm;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; #1;
      chk({tag, "_busy_start"}, busy, 1);
      chk({tag, "_valid_start"}, cfg_valid, 0);
      wait_done(tag, cyc);
      @(negedge clk); #1;
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   task automatic chk_cfg(input string tag, input int d, input int m, input int t,
                          input int sz, input int x, input int y);
      chk({tag, "_dim"}, dim, d);
      chk({tag, "_mines"}, mine_num, m);
      chk({tag, "_timer"}, timer_sec, t);
      chk({tag, "_size"}, board_size, sz);
      chk({tag, "_xpos"}, board_xpos, x);
      chk({tag, "_ypos"}, board_ypos, y);
   endtask

   task automatic chk_map(input string tag, input int d, input int m);
      int pop, mis;
      chk({tag, "_we_cnt"}, we_cnt, m);
      chk({tag, "_dups"}, dup_cnt, 0);
      chk({tag, "_oor"}, oor_cnt, 0);
      scan_map(d, pop, mis);
      chk({tag, "_popcount"}, pop, m);
      chk({tag, "_map_match"}, mis, 0);
   endtask

   initial begin
      int cyc, d0, pop, mis;
      rst = 1'b1; start = 1'b0; level = 2'd0; custom_dim = '0; custom_mines = '0;
      q_row = '0; q_col = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", cfg_valid, 0);
      chk("rst_we", mine_we, 0);
      chk("rst_qmine", q_mine, 0);
      chk_cfg("rst", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      gen("easy", 2'd0, 5'd0, 8'd0, cyc);
      chk_cfg("easy", 8, 19, 45, 512, 256, 128);
      chk_map("easy", 8, 19);

      gen("medium", 2'd1, 5'd0, 8'd0, cyc);
      chk_cfg("medium", 10, 30, 50, 640, 192, 64);
      chk_map("medium", 10, 30);

      gen("hard", 2'd2, 5'd0, 8'd0, cyc);
      chk_cfg("hard", 15, 40, 70, 960, 32, 0);
      chk_map("hard", 15, 40);

      // a fresh EASY board must not inherit HARD mines inside the 8x8 corner
      gen("regen", 2'd0, 5'd0, 8'd0, cyc);
      chk_map("regen", 8, 19);

      gen("cust_small", 2'd3, 5'd2, 8'd200, cyc);
      chk_cfg("cust_small", 4, 15, 60, 256, 384, 256);
      chk_map("cust_small", 4, 15);
      scan_map(4, pop, mis);
      chk("cust_small_free_cells", 16 - pop, 1);

      gen("cust_big", 2'd3, 5'd20, 8'd0, cyc);
      chk_cfg("cust_big", 16, 1, 60, 1024, 0, 0);
      chk_map("cust_big", 16, 1);

      // start held and toggled through a whole generation: exactly one done
      d0 = done_cnt;
      level = 2'd0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); #1;
      chk("hold_busy", busy, 1);
      chk("hold_valid", cfg_valid, 0);
      cyc = 1;
      while (done !== 1'b1 && cyc < BUDGET) begin
         @(negedge clk); start = cyc[0]; #1;
         cyc++;
      end
      start = 1'b0;
      chk("hold_done_seen", done, 1);
      repeat (6) @(negedge clk);
      #1;
      chk("hold_one_done", done_cnt, d0 + 1);
      chk("hold_idle", busy, 0);
      chk_map("hold", 8, 19);

      // async reset in the middle of placement
      level = 2'd2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("midrst_busy_before", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", cfg_valid, 0);
      chk("midrst_done", done, 0);
      chk("midrst_we", mine_we, 0);
      chk("midrst_row", mine_row, 0);
      chk("midrst_col", mine_col, 0);
      chk_cfg("midrst", 0, 0, 0, 0, 0, 0);
      scan_map(16, pop, mis);
      chk("midrst_map", pop, 0);
      @(negedge clk); #2 rst = 1'b0;

      gen("post_rst", 2'd0, 5'd0, 8'd0, cyc);
      chk_cfg("post_rst", 8, 19, 45, 512, 256, 128);
      chk_map("post_rst", 8, 19);

      // densest board: a single free cell must remain
      gen("dense", 2'd3, 5'd16, 8'd255, cyc);
      chk_cfg("dense", 16, 255, 60, 1024, 0, 0);
      chk_map("dense", 16, 255);
      scan_map(16, pop, mis);
      chk("dense_free_cells", 256 - pop, 1);
      chk_lt("dense_latency", cyc, 256 * 1024 + 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
